// File: rtl/ula_multiciclo_if.sv
// ula_multiciclo_if
//   Handshake bundle for the multi-cycle ULA.
//   Request channel : in_valid/in_ready with operands a, b and op code.
//   Response channel: out_valid/out_ready with result, Z/C/V/N flags and err.
//   Status          : busy.
//   Modports: master = producer/consumer side, slave = the ULA itself.
interface ula_multiciclo_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             flag_n;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_n, err, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_n, err, busy
  );
endinterface

// File: rtl/ula_multiciclo.sv
// ula_multiciclo
//   Multi-cycle ULA: one operation per valid/ready handshake. Single-cycle ops
//   (ADD, SUB, AND, OR, NAND, NOR, XOR, SLTU) finish one cycle after accept;
//   shifts (SLL, SRL, SRA) move one bit per BUSY cycle; the optional multiplier
//   is an unsigned shift-add over a 2*WIDTH accumulator.
//   Result, Z/C/V/N and err are registered and held in DONE until out_ready.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : ula_multiciclo_if.slave (in_valid/in_ready, a, b, op,
//          out_valid/out_ready, result, flag_z/c/v/n, err, busy)
// Configuration
//   ULA_MUL_EN : when defined, op 11 is MUL (WIDTH BUSY cycles); otherwise
//                op 11 is illegal and no multiplier logic exists.
module ula_multiciclo #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  ula_multiciclo_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the counter can also hold WIDTH for the multiplier.
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
`ifdef ULA_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
`endif

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] work_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
`ifdef ULA_MUL_EN
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mcand_nxt_s;
  logic [WIDTH:0]     mul_sum_s;
`endif

  logic             accept_s;
  logic             done_load_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;
  logic             err_s;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic             add_v_s;
  logic             sub_v_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] shift_s;
  logic             shout_s;

  logic [WIDTH-1:0] result_r;
  logic             flag_z_r;
  logic             flag_c_r;
  logic             flag_v_r;
  logic             flag_n_r;
  logic             err_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  // Adder/subtractor shared by ADD, SUB and SLTU; SUB is a + ~b + 1 so bit WIDTH is no-borrow.
  always_comb begin
    add_s   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_s   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    add_v_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
    sub_v_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
    shamt_s = bus.b[SHW-1:0];
  end

  // One bit of the serial shifter; SRA keeps the captured sign bit in place.
  always_comb begin
    shift_s = work_r;
    shout_s = 1'b0;
    case (op_r)
      OP_SLL: begin
        shift_s = {work_r[WIDTH-2:0], 1'b0};
        shout_s = work_r[WIDTH-1];
      end
      OP_SRL: begin
        shift_s = {1'b0, work_r[WIDTH-1:1]};
        shout_s = work_r[0];
      end
      OP_SRA: begin
        shift_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
        shout_s = work_r[0];
      end
      default: begin
        shift_s = work_r;
        shout_s = 1'b0;
      end
    endcase
  end

`ifdef ULA_MUL_EN
  // Shift-add step: conditionally add the multiplicand into the upper half.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
  end
`endif

  // Next-state and load decisions for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    done_load_s = 1'b0;
    res_s       = {WIDTH{1'b0}};
    c_s         = 1'b0;
    v_s         = 1'b0;
    err_s       = 1'b0;
    work_nxt_s  = work_r;
    cnt_nxt_s   = cnt_r;
`ifdef ULA_MUL_EN
    acc_nxt_s   = acc_r;
    mcand_nxt_s = mcand_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept_s    = 1'b1;
          // Single-cycle unless an iterative op overrides below.
          state_nxt_s = S_DONE;
          done_load_s = 1'b1;
          case (bus.op)
            OP_ADD: begin
              res_s = add_s[WIDTH-1:0];
              c_s   = add_s[WIDTH];
              v_s   = add_v_s;
            end
            OP_SUB: begin
              res_s = sub_s[WIDTH-1:0];
              c_s   = sub_s[WIDTH];
              v_s   = sub_v_s;
            end
            OP_AND:  res_s = bus.a & bus.b;
            OP_OR:   res_s = bus.a | bus.b;
            OP_NAND: res_s = ~(bus.a & bus.b);
            OP_NOR:  res_s = ~(bus.a | bus.b);
            OP_XOR:  res_s = bus.a ^ bus.b;
            OP_SLTU: begin
              res_s = {{(WIDTH-1){1'b0}}, ~sub_s[WIDTH]};
              c_s   = sub_s[WIDTH];
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              if (shamt_s == {SHW{1'b0}}) begin
                res_s = bus.a;
              end else begin
                state_nxt_s = S_BUSY;
                done_load_s = 1'b0;
                work_nxt_s  = bus.a;
                cnt_nxt_s   = {1'b0, shamt_s};
              end
            end
`ifdef ULA_MUL_EN
            OP_MUL: begin
              state_nxt_s = S_BUSY;
              done_load_s = 1'b0;
              acc_nxt_s   = {{WIDTH{1'b0}}, bus.b};
              mcand_nxt_s = bus.a;
              cnt_nxt_s   = CW'(WIDTH);
            end
`endif
            default: begin
              res_s = {WIDTH{1'b0}};
              err_s = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_nxt_s  = cnt_r - CNT_ONE;
        work_nxt_s = shift_s;
`ifdef ULA_MUL_EN
        acc_nxt_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
`endif
        // The step taken while the count is one is the last; load results directly.
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = S_DONE;
          done_load_s = 1'b1;
`ifdef ULA_MUL_EN
          if (op_r == OP_MUL) begin
            res_s = acc_nxt_s[WIDTH-1:0];
            c_s   = |acc_nxt_s[2*WIDTH-1:WIDTH];
          end else begin
            res_s = shift_s;
            c_s   = shout_s;
          end
`else
          res_s = shift_s;
          c_s   = shout_s;
`endif
        end else begin
          state_nxt_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State register; handshake/status outputs are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_DONE);
      busy_r      <= (state_nxt_s != S_IDLE);
    end
  end

  // Captured op code plus the iteration datapath (shifter, counter, multiplier).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= 4'd0;
      work_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
`ifdef ULA_MUL_EN
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
`endif
    end else begin
      if (accept_s) begin
        op_r <= bus.op;
      end else begin
        op_r <= op_r;
      end
      work_r  <= work_nxt_s;
      cnt_r   <= cnt_nxt_s;
`ifdef ULA_MUL_EN
      acc_r   <= acc_nxt_s;
      mcand_r <= mcand_nxt_s;
`endif
    end
  end

  // Result and flags, loaded only on entry to DONE so they stay stable while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= {WIDTH{1'b0}};
      flag_z_r <= 1'b0;
      flag_c_r <= 1'b0;
      flag_v_r <= 1'b0;
      flag_n_r <= 1'b0;
      err_r    <= 1'b0;
    end else if (done_load_s) begin
      result_r <= res_s;
      flag_z_r <= (res_s == {WIDTH{1'b0}});
      flag_c_r <= c_s;
      flag_v_r <= v_s;
      flag_n_r <= res_s[WIDTH-1];
      err_r    <= err_s;
    end else begin
      result_r <= result_r;
      flag_z_r <= flag_z_r;
      flag_c_r <= flag_c_r;
      flag_v_r <= flag_v_r;
      flag_n_r <= flag_n_r;
      err_r    <= err_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.result    = result_r;
  assign bus.flag_z    = flag_z_r;
  assign bus.flag_c    = flag_c_r;
  assign bus.flag_v    = flag_v_r;
  assign bus.flag_n    = flag_n_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo
//   Scoreboard bench for ula_multiciclo (WIDTH=16). The driver pushes the
//   reference-model response at accept; the monitor pops on each new out_valid
//   and checks value, flags, latency and BUSY length, and re-checks the held
//   outputs on every stalled DONE cycle. Consumer stalls are randomised.
module tb_ula_multiciclo;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ula_multiciclo_if #(.WIDTH(W)) bus ();

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] r;
    logic        z, c, v, n, err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   stall_next = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain arithmetic on integers.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int unsigned ua, ub, full;
    int sa, sb, sr, n;
    longint unsigned prod;
    logic signed [15:0] as;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    n = b[3:0];
    as = a;
    e.r = 16'h0; e.c = 1'b0; e.v = 1'b0; e.err = 1'b0; e.lat = 1;
    case (op)
      4'd0: begin full = ua + ub; e.r = full[15:0]; e.c = (full > 32'd65535);
              sr = sa + sb; e.v = (sr > 32767) || (sr < -32768); end
      4'd1: begin e.r = a - b; e.c = (ua >= ub);
              sr = sa - sb; e.v = (sr > 32767) || (sr < -32768); end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = ~(a & b);
      4'd5: e.r = ~(a | b);
      4'd6: e.r = a ^ b;
      4'd7: begin e.r = (ua < ub) ? 16'd1 : 16'd0; e.c = (ua >= ub); end
      4'd8: begin e.r = a << n; e.c = (n == 0) ? 1'b0 : a[16-n]; e.lat = n + 1; end
      4'd9: begin e.r = a >> n; e.c = (n == 0) ? 1'b0 : a[n-1]; e.lat = n + 1; end
      4'd10: begin e.r = as >>> n; e.c = (n == 0) ? 1'b0 : a[n-1]; e.lat = n + 1; end
`ifdef ULA_MUL_EN
      4'd11: begin prod = longint'(ua) * longint'(ub); e.r = prod[15:0];
               e.c = (prod[31:16] != 16'h0); e.lat = 17; end
`endif
      default: begin e.r = 16'h0; e.err = 1'b1; end
    endcase
    e.z = (e.r == 16'h0);
    e.n = e.r[15];
    return e;
  endfunction

  // Driver: call at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int stall);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) exp_q.push_back(model(op, a, b));
    else begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: in_ready actual 0 required 1 for op %0d", op);
    end
    @(posedge clk); #1;
    if (ok) stall_next = stall;
    // Scramble inputs after accept; the captured op must be unaffected.
    bus.in_valid = 1'b0; bus.op = 4'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
  endtask

  // Consumer: out_ready with a per-transaction stall count.
  int  stall_cnt = 0;
  bit  pv_c = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      bus.out_ready = 1'b1; pv_c = 1'b0; stall_cnt = 0;
    end else begin
      if (bus.out_valid && !pv_c) begin
        stall_cnt = (stall_next >= 0) ? stall_next : int'($urandom_range(0, 2));
        stall_next = -1;
      end
      if (bus.out_valid) begin
        bus.out_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      pv_c = bus.out_valid;
    end
  end

  // Monitor: scoreboard pop/compare, held-output checks, latency and watchdog.
  int   cyc = 0;
  int   stamp_q[$];
  int   busy_cnt = 0;
  bit   prev_valid = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;
  int   st;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stamp_q.delete(); prev_valid = 1'b0; have_cur = 1'b0; busy_cnt = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        stamp_q.push_back(cyc); busy_cnt = 0;
      end
      if (bus.out_valid) begin
        chk("in_ready_in_done", bus.in_ready, 32'd0);
        if (!prev_valid) begin
          if (exp_q.size() == 0 || stamp_q.size() == 0) begin
            vectors++; miscompares++; have_cur = 1'b0;
            $display("FAIL unexpected_out_valid: actual 1 required 0");
          end else begin
            cur = exp_q.pop_front();
            st = stamp_q.pop_front();
            have_cur = 1'b1;
            chk("latency", cyc - st, cur.lat);
            chk("busy_cycles", busy_cnt, cur.lat - 1);
          end
        end
        if (have_cur) begin
          chk("result", {16'h0, bus.result}, {16'h0, cur.r});
          chk("err_z_c_v_n", {bus.err, bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n},
              {cur.err, cur.z, cur.c, cur.v, cur.n});
        end
      end else begin
        have_cur = 1'b0;
        chk("ready_vs_busy", bus.in_ready, !bus.busy);
        if (bus.busy) busy_cnt++;
        if (stamp_q.size() > 0 && (cyc - stamp_q[0]) > 60) begin
          vectors++; miscompares++;
          $display("FAIL out_valid_timeout: no result %0d cycles after accept", cyc - stamp_q[0]);
          void'(stamp_q.pop_front());
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.op = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 32'd1);
    chk("reset_out_valid", bus.out_valid, 32'd0);
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_flags_err", {bus.err, bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    issue(4'd0,  16'hFFFF, 16'h0001, 0);
    issue(4'd1,  16'h8000, 16'h0001, 1);
    issue(4'd7,  16'h0003, 16'h0005, 0);
    issue(4'd7,  16'h0005, 16'h0003, 0);
    issue(4'd10, 16'h8000, 16'h0004, 3);
    issue(4'd8,  16'h0001, 16'h0000, 0);
    issue(4'd9,  16'h0003, 16'h0001, 0);
    issue(4'd11, 16'h0100, 16'h0100, 0);
    issue(4'd13, 16'h1234, 16'h5678, 2);
    issue(4'd0,  16'h7FFF, 16'h0001, 0);
    issue(4'd4,  16'hF0F0, 16'hFF00, 0);
    issue(4'd8,  16'h8001, 16'h000F, 0);

    // Reset while an SLL by 15 is six cycles into execution.
    issue(4'd8, 16'h0001, 16'h000F, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midop_rst_out_valid", bus.out_valid, 32'd0);
    chk("midop_rst_busy", bus.busy, 32'd0);
    chk("midop_rst_in_ready", bus.in_ready, 32'd1);
    chk("midop_rst_result", bus.result, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    issue(4'd1, 16'h0005, 16'h0003, 0);

    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), -1);
    end

    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
